// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned PC_SIZE = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_JALR = 2'b01;
  localparam logic [1:0] PCSEL_BXX  = 2'b10;
  localparam logic [1:0] PCSEL_PEND = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MISS_REQ,
    ST_REFILL,
    ST_RESUME
  } fetch_state_e;

endpackage

// File: rtl/fetch_refill_cnt.sv
// Refill beat counter: produces icache write strobe, word index and line-complete pulse.
module fetch_refill_cnt #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned BEAT_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ack_first,
  input  logic              ack_beat,
  output logic              last_beat,
  output logic              ic_wr_en,
  output logic [BEAT_W-1:0] ic_wr_idx,
  output logic              ic_fill_done
);

  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(LINE_WORDS - 1);

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    last_beat    = (beat_cnt_q == LAST_IDX);
    ic_wr_en     = ack_first | ack_beat;
    ic_wr_idx    = ack_first ? '0 : beat_cnt_q;
    ic_fill_done = ack_beat & last_beat;
    if (ack_first) begin
      beat_cnt_d = BEAT_W'(1);
    end else if (ack_beat) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: PC source select, NOP bubbles, icache miss refill and deferred redirects.
module fetch_ctrl #(
  parameter int unsigned PC_SIZE    = fetch_ctrl_pkg::PC_SIZE,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned BEAT_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] pc,
  input  logic               ic_hit,
  input  logic               id_stall,
  input  logic               id_jalr,
  input  logic               predict_fail,
  input  logic [PC_SIZE-1:0] redir_target,
  output logic               if_en,
  output logic [1:0]         pc_sel,
  output logic [PC_SIZE-1:0] pend_pc,
  output logic               instr_nop_sel,
  output logic               mem_req,
  output logic [PC_SIZE-1:0] mem_addr,
  input  logic               mem_ack,
  output logic               ic_wr_en,
  output logic [BEAT_W-1:0]  ic_wr_idx,
  output logic               ic_fill_done
);
  import fetch_ctrl_pkg::*;

  localparam logic [PC_SIZE-1:0] LINE_MASK = PC_SIZE'(LINE_WORDS * 4 - 1);

  fetch_state_e       state_q, state_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_bxx_q, pend_bxx_d;
  logic [PC_SIZE-1:0] pend_pc_q, pend_pc_d;
  logic [PC_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic               ack_first, ack_beat, last_beat;
  logic               redirect, latch_redir;

  assign redirect = predict_fail | id_jalr;
  assign pend_pc  = pend_pc_q;
  assign mem_addr = mem_addr_q;

  fetch_refill_cnt #(
    .LINE_WORDS (LINE_WORDS),
    .BEAT_W     (BEAT_W)
  ) u_refill_cnt (
    .clk          (clk),
    .rst          (rst),
    .ack_first    (ack_first),
    .ack_beat     (ack_beat),
    .last_beat    (last_beat),
    .ic_wr_en     (ic_wr_en),
    .ic_wr_idx    (ic_wr_idx),
    .ic_fill_done (ic_fill_done)
  );

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_bxx_d    = pend_bxx_q;
    pend_pc_d     = pend_pc_q;
    mem_addr_d    = mem_addr_q;
    if_en         = 1'b0;
    instr_nop_sel = 1'b1;
    pc_sel        = PCSEL_SEQ;
    mem_req       = 1'b0;
    ack_first     = 1'b0;
    ack_beat      = 1'b0;
    latch_redir   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if_en         = redirect | (!id_stall & ic_hit);
        instr_nop_sel = !ic_hit | id_stall | redirect;
        if (predict_fail) begin
          pc_sel = PCSEL_BXX;
        end else if (id_jalr) begin
          pc_sel = PCSEL_JALR;
        end
        if (!redirect && !ic_hit && !id_stall) begin
          mem_addr_d = pc & ~LINE_MASK;
          state_d    = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        mem_req     = 1'b1;
        latch_redir = 1'b1;
        if (mem_ack) begin
          ack_first = 1'b1;
          state_d   = ST_REFILL;
        end
      end
      ST_REFILL: begin
        latch_redir = 1'b1;
        if (mem_ack) begin
          ack_beat = 1'b1;
          if (last_beat) begin
            state_d = ST_RESUME;
          end
        end
      end
      ST_RESUME: begin
        // A redirect arriving here is latched and RESUME repeats, so it is never dropped.
        if (redirect) begin
          latch_redir = 1'b1;
        end else if (pend_valid_q) begin
          if (!id_stall) begin
            pc_sel       = PCSEL_PEND;
            if_en        = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // A latched mispredict can only be replaced by another mispredict.
    if (latch_redir && (predict_fail || (id_jalr && !(pend_valid_q && pend_bxx_q)))) begin
      pend_pc_d    = redir_target;
      pend_valid_d = 1'b1;
      pend_bxx_d   = predict_fail;
    end

    if (rst) begin
      if_en         = 1'b0;
      instr_nop_sel = 1'b1;
      pc_sel        = PCSEL_SEQ;
      mem_req       = 1'b0;
      ack_first     = 1'b0;
      ack_beat      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pend_valid_q <= 1'b0;
      pend_bxx_q   <= 1'b0;
      pend_pc_q    <= '0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_bxx_q   <= pend_bxx_d;
      pend_pc_q    <= pend_pc_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: per-cycle table plus a bounded miss handshake sequence.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ic_hit, id_stall, id_jalr, predict_fail;
  logic [31:0] redir_target;
  logic        if_en;
  logic [1:0]  pc_sel;
  logic [31:0] pend_pc;
  logic        instr_nop_sel;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        ic_wr_en;
  logic [1:0]  ic_wr_idx;
  logic        ic_fill_done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fetch_ctrl #(
    .PC_SIZE    (32),
    .LINE_WORDS (4),
    .BEAT_W     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .ic_hit        (ic_hit),
    .id_stall      (id_stall),
    .id_jalr       (id_jalr),
    .predict_fail  (predict_fail),
    .redir_target  (redir_target),
    .if_en         (if_en),
    .pc_sel        (pc_sel),
    .pend_pc       (pend_pc),
    .instr_nop_sel (instr_nop_sel),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .ic_wr_en      (ic_wr_en),
    .ic_wr_idx     (ic_wr_idx),
    .ic_fill_done  (ic_fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, hit, stall, jalr, pf, ack;
    logic [31:0] pc, tgt;
    logic        e_if, e_nop, e_req, e_wr, e_done;
    logic [1:0]  e_sel, e_idx;
    logic [31:0] e_addr, e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic [31:0] p, input logic h,
                     input logic s, input logic j, input logic f, input logic [31:0] t,
                     input logic a, input logic ei, input logic en, input logic [1:0] es,
                     input logic eq, input logic [31:0] ea, input logic ew,
                     input logic [1:0] ex, input logic ed, input logic [31:0] ep);
    vec_t v;
    v.name = n; v.rst = r; v.pc = p; v.hit = h; v.stall = s; v.jalr = j; v.pf = f;
    v.tgt = t; v.ack = a; v.e_if = ei; v.e_nop = en; v.e_sel = es; v.e_req = eq;
    v.e_addr = ea; v.e_wr = ew; v.e_idx = ex; v.e_done = ed; v.e_pend = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input int unsigned i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h, want %h", n, i, act, exp);
  endtask

  initial begin
    int unsigned writes;
    int unsigned fills;
    bit          seen;

    rst = 1'b1; pc = 32'h100; ic_hit = 1'b1; id_stall = 1'b0; id_jalr = 1'b0;
    predict_fail = 1'b0; redir_target = '0; mem_ack = 1'b0;

    //   name         rst pc        hit stl jal pf  tgt       ack | if nop sel req addr      wr idx dn pend
    add("rst",          1, 32'h100, 1, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("rst",          1, 32'h100, 1, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("rst",          1, 32'h100, 1, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("run_hit",      0, 32'h100, 1, 0, 0, 0, 32'h0,   0,  1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("redir_pf",     0, 32'h104, 1, 1, 1, 1, 32'h200, 0,  1, 1, 2, 0, 32'h0,   0, 0, 0, 32'h0);
    add("redir_jalr",   0, 32'h200, 0, 0, 1, 0, 32'h240, 0,  1, 1, 1, 0, 32'h0,   0, 0, 0, 32'h0);
    add("stall_hit",    0, 32'h240, 1, 1, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("stall_miss",   0, 32'h240, 0, 1, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("run_hit2",     0, 32'h240, 1, 0, 0, 0, 32'h0,   0,  1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("miss2",        0, 32'h104, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("req2",         0, 32'h104, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 1, 32'h100, 0, 0, 0, 32'h0);
    add("b2_0",         0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 1, 32'h100, 1, 0, 0, 32'h0);
    add("b2_1",         0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 1, 0, 32'h0);
    add("b2_2",         0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 2, 0, 32'h0);
    add("b2_3",         0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 3, 1, 32'h0);
    add("resume2",      0, 32'h104, 1, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("run2",         0, 32'h104, 1, 0, 0, 0, 32'h0,   0,  1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("miss4",        0, 32'h208, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("req4",         0, 32'h208, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 1, 32'h200, 0, 0, 0, 32'h0);
    add("b4_0",         0, 32'h208, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 1, 32'h200, 1, 0, 0, 32'h0);
    add("b4_1_jalr",    0, 32'h208, 0, 1, 1, 0, 32'h300, 1,  0, 1, 0, 0, 32'h0,   1, 1, 0, 32'h0);
    add("b4_2",         0, 32'h208, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 2, 0, 32'h300);
    add("b4_3",         0, 32'h208, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 3, 1, 32'h300);
    add("resume4",      0, 32'h208, 1, 0, 0, 0, 32'h0,   0,  1, 1, 3, 0, 32'h0,   0, 0, 0, 32'h300);
    add("run4",         0, 32'h300, 1, 0, 0, 0, 32'h0,   0,  1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h300);
    add("miss5",        0, 32'h404, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h300);
    add("req5_pf",      0, 32'h404, 0, 0, 0, 1, 32'h500, 0,  0, 1, 0, 1, 32'h400, 0, 0, 0, 32'h300);
    add("b5_0_jalr",    0, 32'h404, 0, 0, 1, 0, 32'h600, 1,  0, 1, 0, 1, 32'h400, 1, 0, 0, 32'h500);
    add("gap5a",        0, 32'h404, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h500);
    add("gap5b",        0, 32'h404, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h500);
    add("b5_1",         0, 32'h404, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 1, 0, 32'h500);
    add("b5_2",         0, 32'h404, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 2, 0, 32'h500);
    add("gap5c",        0, 32'h404, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h500);
    add("b5_3",         0, 32'h404, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 3, 1, 32'h500);
    add("resume5_stl",  0, 32'h404, 1, 1, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h500);
    add("resume5",      0, 32'h404, 1, 0, 0, 0, 32'h0,   0,  1, 1, 3, 0, 32'h0,   0, 0, 0, 32'h500);
    add("run5",         0, 32'h500, 1, 0, 0, 0, 32'h0,   0,  1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h500);
    add("miss6",        0, 32'h104, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h500);
    add("b6_0",         0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 1, 32'h100, 1, 0, 0, 32'h500);
    add("b6_1",         0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 1, 0, 32'h500);
    add("rst6",         1, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h500);
    add("after_rst6",   0, 32'h104, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("req6b",        0, 32'h104, 0, 0, 0, 0, 32'h0,   0,  0, 1, 0, 1, 32'h100, 0, 0, 0, 32'h0);
    add("b6b_0",        0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 1, 32'h100, 1, 0, 0, 32'h0);
    add("b6b_1",        0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 1, 0, 32'h0);
    add("b6b_2",        0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 2, 0, 32'h0);
    add("b6b_3",        0, 32'h104, 0, 0, 0, 0, 32'h0,   1,  0, 1, 0, 0, 32'h0,   1, 3, 1, 32'h0);
    add("resume6",      0, 32'h104, 1, 0, 0, 0, 32'h0,   0,  0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0);
    add("run6",         0, 32'h104, 1, 0, 0, 0, 32'h0,   0,  1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; pc = vecs[i].pc; ic_hit = vecs[i].hit; id_stall = vecs[i].stall;
      id_jalr = vecs[i].jalr; predict_fail = vecs[i].pf; redir_target = vecs[i].tgt;
      mem_ack = vecs[i].ack;
      #1;
      chk({vecs[i].name, ".if_en"},   i, 32'(if_en),         32'(vecs[i].e_if));
      chk({vecs[i].name, ".nop"},     i, 32'(instr_nop_sel), 32'(vecs[i].e_nop));
      chk({vecs[i].name, ".pc_sel"},  i, 32'(pc_sel),        32'(vecs[i].e_sel));
      chk({vecs[i].name, ".mem_req"}, i, 32'(mem_req),       32'(vecs[i].e_req));
      chk({vecs[i].name, ".wr_en"},   i, 32'(ic_wr_en),      32'(vecs[i].e_wr));
      chk({vecs[i].name, ".done"},    i, 32'(ic_fill_done),  32'(vecs[i].e_done));
      chk({vecs[i].name, ".pend_pc"}, i, pend_pc,            vecs[i].e_pend);
      if (vecs[i].e_wr)  chk({vecs[i].name, ".wr_idx"},   i, 32'(ic_wr_idx), 32'(vecs[i].e_idx));
      if (vecs[i].e_req) chk({vecs[i].name, ".mem_addr"}, i, mem_addr,       vecs[i].e_addr);
    end

    // Handshake-driven miss: wait for mem_req with a bound, then ack until the line completes.
    @(negedge clk);
    pc = 32'h7C; ic_hit = 1'b0; mem_ack = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); #1;
      seen = mem_req;
    end
    chk("hs.req_seen", 0, 32'(seen), 32'd1);
    chk("hs.mem_addr", 0, mem_addr, 32'h70);
    writes = 0; fills = 0;
    mem_ack = 1'b1;
    for (int c = 0; c < 8 && fills == 0; c++) begin
      #1;
      if (ic_wr_en) begin
        chk("hs.wr_idx", writes, 32'(ic_wr_idx), writes);
        writes++;
      end
      if (ic_fill_done) fills++;
      @(negedge clk);
    end
    mem_ack = 1'b0; ic_hit = 1'b1;
    chk("hs.writes", 0, writes, 32'd4);
    chk("hs.fills",  0, fills,  32'd1);
    #1;
    chk("hs.resume_if_en", 0, 32'(if_en), 32'd0);
    @(negedge clk); #1;
    chk("hs.run_if_en", 0, 32'(if_en), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
